// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) then opcode-dependent execute
// steps (T3-T6), one state per clock, Moore strobes decoded from state and ir.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDMuxread,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        LOin,
    output logic        HIin,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHL,
    output logic        SHRA,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        MUL,
    output logic        DIV,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    state_t      state, next_state;
    logic        done_q;
    logic        alu_go;
    logic [12:0] alu_sel;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic        op_binary, op_unary, op_muldiv, op_legal;
    logic        wb_last;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign op_binary = (opcode <= 5'd8);
    assign op_unary  = (opcode == 5'd9) || (opcode == 5'd10);
    assign op_muldiv = (opcode == 5'd11) || (opcode == 5'd12);
    assign op_legal  = (opcode <= 5'd12);

    // Final writeback step of each legal instruction class; arms done for the next IDLE cycle.
    assign wb_last = ((state == T4) && op_unary) ||
                     ((state == T5) && op_binary) ||
                     (state == T6);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= next_state;
            done_q <= wb_last;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    next_state = run ? T0 : IDLE;
            T0:      next_state = T1;
            T1:      next_state = T2;
            T2:      next_state = T3;
            T3:      next_state = op_legal ? T4 : IDLE;
            T4:      next_state = op_unary ? IDLE : T5;
            T5:      next_state = op_binary ? IDLE : T6;
            T6:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        PCout     = 1'b0;
        PCin      = 1'b0;
        IncPC     = 1'b0;
        MARin     = 1'b0;
        MDMuxread = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zlowin    = 1'b0;
        Zhighin   = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        LOin      = 1'b0;
        HIin      = 1'b0;
        Rin       = '0;
        Rout      = '0;
        alu_go    = 1'b0;
        illegal   = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            T1: begin
                Zlowout   = 1'b1;
                PCin      = 1'b1;
                MDMuxread = 1'b1;
                MDRin     = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (!op_legal) begin
                    illegal = 1'b1;
                end else if (op_unary) begin
                    Rout   = 16'h0001 << rb;
                    alu_go = 1'b1;
                    Zlowin = 1'b1;
                end else begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                if (op_unary) begin
                    Zlowout = 1'b1;
                    Rin     = 16'h0001 << ra;
                end else begin
                    Rout    = 16'h0001 << rc;
                    alu_go  = 1'b1;
                    Zlowin  = 1'b1;
                    Zhighin = op_muldiv;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (op_muldiv) LOin = 1'b1;
                else           Rin  = 16'h0001 << ra;
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_sel = alu_go ? (13'd1 << opcode) : '0;
    assign {DIV, MUL, NOT, NEG, ROL, ROR, SHRA, SHL, SHR, OR, AND, SUB, ADD} = alu_sel;
    assign done = done_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port: clock  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: clear  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 SHALL have port: run  in  1  start request, sampled only in IDLE.
REQ-004 SHALL have port: ir  in  32  instruction register contents: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-005 SHALL have ports: PCout, PCin, IncPC, MARin, MDMuxread, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
REQ-006 SHALL have ports: Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin  out  1 each  Z/HI/LO strobes.
REQ-007 SHALL have ports: ADD, SUB, AND, OR, SHR, SHL, SHRA, ROR, ROL, NEG, NOT, MUL, DIV  out  1 each  ALU op select.
REQ-008 SHALL have ports: Rin, Rout  out  16 each  one-hot general-register load/drive selects (bit n = Rn).
REQ-009 SHALL have ports: busy, done, illegal  out  1 each  status.

Function
REQ-010 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6; one state per clock; all outputs Moore-decoded from state and ir.
REQ-011 SHALL go IDLE->T0 on a clock edge with run=1; otherwise remain in IDLE.
REQ-012 SHALL drive fetch steps: T0 PCout, MARin, IncPC, Zlowin; T1 Zlowout, PCin, MDMuxread, MDRin; T2 MDRout, IRin.
REQ-013 SHALL decode opcodes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SHR, 00101 SHL, 00110 SHRA, 00111 ROR, 01000 ROL, 01001 NEG, 01010 NOT, 01011 MUL, 01100 DIV.
REQ-014 SHALL, for binary ops (00000-01000), drive T3 Rout[Rb], Yin; T4 Rout[Rc], op, Zlowin; T5 Zlowout, Rin[Ra]; then IDLE.
REQ-015 SHALL, for NEG/NOT, drive T3 Rout[Rb], op, Zlowin; T4 Zlowout, Rin[Ra]; then IDLE.
REQ-016 SHALL, for MUL/DIV, drive T3 Rout[Rb], Yin; T4 Rout[Rc], op, Zlowin, Zhighin; T5 Zlowout, LOin; T6 Zhighout, HIin; then IDLE.
REQ-017 SHALL decode opcode from ir in T3 onward (ir valid after T2 load).
REQ-018 SHALL, for opcodes 01101-11111, assert illegal for one cycle in T3, drive no other strobe in T3, and return to IDLE; no register written.
REQ-019 SHALL keep Rin and Rout at most one bit set; all zero outside the steps listed.
REQ-020 SHALL assert busy in T0-T6, deasserted in IDLE.
REQ-021 SHALL assert done for exactly one cycle: the first IDLE cycle following a completed writeback step; not after illegal.
REQ-022 SHALL accept a new run in that same IDLE cycle, so back-to-back instructions have exactly one IDLE cycle between them.
REQ-023 SHALL ignore run while busy.
REQ-024 Latency run-edge to done: 7 cycles binary, 6 unary, 8 MUL/DIV.

Reset
REQ-025 SHALL on clear=0, immediately (asynchronously) enter IDLE and force every output to 0, including done and illegal.
REQ-026 SHALL, on reset mid-instruction, abandon it with no further strobes; no done pulse on release.
REQ-027 SHALL stay in IDLE while clear=0 regardless of run.

Verification
REQ-028 SHL: ir=0x28918000, run pulse -> T3 Rout=0x0004 Yin; T4 Rout=0x0008 SHL Zlowin; T5 Zlowout Rin=0x0002; done next cycle.
REQ-029 MUL: ir=0x581A0000 -> T3 Rout=0x0008 Yin; T4 Rout=0x0010 MUL Zlowin Zhighin; T5 Zlowout LOin; T6 Zhighout HIin; done next cycle.
REQ-030 NEG: ir=0x4AB00000 -> T3 Rout=0x0040 NEG Zlowin; T4 Zlowout Rin=0x0020; done next cycle.
REQ-031 Illegal: ir=0xF8000000 -> fetch T0-T2, illegal=1 in T3 with Rin=Rout=0, then IDLE, no done.
REQ-032 Reset: clear=0 asserted mid-T4 of SHL -> all outputs 0 before next edge, state IDLE, no Rin pulse, no done.
REQ-033 Back-to-back: run held 1 with SHL ir -> T0..T5, one IDLE cycle with done=1, T0 on following edge.
